// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment encodings (active-low {dp, g..a}) and blank code
package seg_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex nibble to active-low segments g..a
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);
    assign seg_n = SEG_HEX[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame-atomic load, leading-zero blanking and blink
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic                      load,
    input  logic                      lz_blank,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                seg,
    output logic                      frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] dig;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
    } buf_t;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         fc_q, fc_d;
    logic                  ph_q, ph_d;
    buf_t                  pend_q, pend_d, act_q, act_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  fd_q, fd_d;
    logic                  tick, wrap, lz_hit, blink_hit;
    logic [3:0]            nib;
    logic [6:0]            hex_seg;
    // A load on the wrap edge reaches active through pend_d, so the new frame starts clean.
    always_comb begin
        tick   = cnt_q == CW'(REFRESH_DIV - 1);
        wrap   = tick && idx_q == '0;
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = !tick ? idx_q : wrap ? IW'(NUM_DIGITS - 1) : idx_q - 1'b1;
        pend_d = load ? {digits_in, dp_in, blink_in} : pend_q;
        act_d  = wrap ? pend_d : act_q;
        fc_d   = !wrap ? fc_q : (fc_q == BW'(BLINK_FRAMES - 1)) ? '0 : fc_q + 1'b1;
        ph_d   = ph_q ^ (wrap && fc_q == BW'(BLINK_FRAMES - 1));
        nib    = act_d.dig[4*idx_d +: 4];
    end
    seg_hex_decode u_dec (.hex(nib), .seg_n(hex_seg));
    always_comb begin
        lz_hit    = lz_blank && idx_d != '0 && (act_d.dig >> (4*idx_d)) == '0;
        blink_hit = ph_d && act_d.blink[idx_d];
        an_d      = tick ? ~(NUM_DIGITS'(1) << idx_d) : an_q;
        seg_d     = !tick ? seg_q : blink_hit ? SEG_BLANK : {~act_d.dp[idx_d], lz_hit ? 7'h7F : hex_seg};
        fd_d      = wrap;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            fc_q   <= '0;
            ph_q   <= 1'b0;
            pend_q <= '0;
            act_q  <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            fc_q   <= fc_d;
            ph_q   <= ph_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            fd_q   <= fd_d;
        end
    end
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, 4-cycle slots, 2-frame blink)
module tb_seg_scan_ctrl;
    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ph = 0;
    int          nframes = 0;
    logic [3:0]  e_an = 4'hF;
    logic [7:0]  e_seg = 8'hFF;
    always #5 clk = ~clk;
    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blink_in(blink_in),
        .load(load), .lz_blank(lz_blank), .an(an), .seg(seg), .frame_done(frame_done)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                                           input int d, input logic lz, input logic phase);
        logic [7:0] s;
        if (phase && bl[d]) return 8'hFF;
        s = HEX[v[4*d +: 4]];
        if (lz && d != 0 && (v >> (4*d)) == 16'h0) s = 8'hFF;
        s[7] = ~dp[d];
        return s;
    endfunction
    // Frame k after reset is blink phase floor(k/2) mod 2.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
        logic       phase;
        logic [3:0] a;
        nframes++;
        phase = ((nframes / 2) % 2) == 1;
        for (int d = 3; d >= 0; d--) begin
            a = ~(4'b0001 << d);
            sb.push_back('{an: a, seg: exp_seg(v, dp, bl, d, lz, phase), fd: (d == 3)});
        end
    endtask
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (ph == 3) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                e_an = e.an;
                e_seg = e.seg;
                chk("tick_an", an, e.an);
                chk("tick_seg", seg, e.seg);
                chk("tick_fd", frame_done, e.fd);
            end
        end else begin
            chk("hold_an", an, e_an);
            chk("hold_seg", seg, e_seg);
            chk("hold_fd", frame_done, 0);
        end
        ph = (ph + 1) % 4;
    endtask
    task automatic next_tick();
        do step(); while (ph != 0);
    endtask
    task automatic run_frames(input int n);
        repeat (4 * n) next_tick();
    endtask
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_an", an, 4'hF);
            chk("rst_seg", seg, 8'hFF);
            chk("rst_fd", frame_done, 0);
        end
        rst = 1'b0;
        ph = 0;
        nframes = 0;
        e_an = 4'hF;
        e_seg = 8'hFF;
        sb.delete();
    endtask
    task automatic load_val(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        digits_in = v;
        dp_in = dp;
        blink_in = bl;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask
    initial begin
        do_reset(2);
        load_val(16'h1234, 4'h0, 4'h0);
        push_frame(16'h1234, 4'h0, 4'h0, 1'b0);
        push_frame(16'h1234, 4'h0, 4'h0, 1'b0);
        run_frames(2);
        load_val(16'h00A0, 4'h0, 4'h0);
        lz_blank = 1'b1;
        push_frame(16'h00A0, 4'h0, 4'h0, 1'b1);
        run_frames(1);
        lz_blank = 1'b0;
        push_frame(16'h00A0, 4'h0, 4'h0, 1'b0);
        run_frames(1);
        load_val(16'h1111, 4'h0, 4'h0);
        push_frame(16'h1111, 4'h0, 4'h0, 1'b0);
        push_frame(16'h1111, 4'h0, 4'h0, 1'b0);
        run_frames(1);
        next_tick();
        next_tick();
        load_val(16'h5555, 4'h0, 4'h0);
        push_frame(16'h5555, 4'h0, 4'h0, 1'b0);
        next_tick();
        next_tick();
        run_frames(1);
        load_val(16'h0008, 4'b0001, 4'b0001);
        repeat (5) push_frame(16'h0008, 4'b0001, 4'b0001, 1'b0);
        run_frames(5);
        repeat (3) step();
        push_frame(16'h9ABC, 4'h0, 4'h0, 1'b0);
        load_val(16'h9ABC, 4'h0, 4'h0);
        next_tick();
        next_tick();
        next_tick();
        push_frame(16'h9ABC, 4'h0, 4'h0, 1'b0);
        next_tick();
        next_tick();
        next_tick();
        do_reset(1);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
        run_frames(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot, legal >=2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period, legal >=1.
REQ-004 SHALL have ports: clk  in  1  system clock; one clock; all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports: digits_in  in  4*NUM_DIGITS  hex value per digit; digit i at bits [4i+3:4i]; digit 0 least significant.
REQ-007 SHALL have ports: dp_in  in  NUM_DIGITS  decimal point enable per digit.
REQ-008 SHALL have ports: blink_in  in  NUM_DIGITS  blink enable per digit.
REQ-009 SHALL have ports: load  in  1  single-cycle strobe capturing digits_in/dp_in/blink_in.
REQ-010 SHALL have ports: lz_blank  in  1  leading-zero blanking mode, sampled continuously.
REQ-011 SHALL have ports: an  out  NUM_DIGITS  anode select, active-low, one-hot-zero.
REQ-012 SHALL have ports: seg  out  8  active-low; bit 7 = dp, bits 6..0 = g..a.
REQ-013 SHALL have ports: frame_done  out  1  one-cycle pulse per completed scan frame.

Function
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; tick is asserted in the cycle the count equals REFRESH_DIV-1.
REQ-015 SHALL hold digit index idx; on tick, idx moves down by one, wrapping from 0 to NUM_DIGITS-1.
REQ-016 SHALL register an and seg on the tick edge for the new idx; an[idx]=0, all other bits 1; outputs are held constant between ticks.
REQ-017 SHALL capture inputs into a pending buffer on any edge with load=1; a later load overwrites pending.
REQ-018 SHALL copy pending into the active buffer on the wrap tick (idx 0 -> NUM_DIGITS-1), so one frame never mixes old and new values.
REQ-019 SHALL, when load and wrap tick coincide, commit the value presented on that cycle to active.
REQ-020 SHALL assert frame_done for exactly one cycle, registered, on the wrap tick edge.
REQ-021 SHALL decode hex 0-F onto segments g..a; values A-F are displayed, not left undefined.
REQ-022 SHALL, with lz_blank=1, blank segments g..a of every zero digit above the most significant nonzero digit; digit 0 is never blanked; dp is unaffected.
REQ-023 SHALL toggle blink phase each BLINK_FRAMES wraps; while phase=1, digits with active blink bit drive seg=8'hFF, dp included, and the anode is still driven.
REQ-024 SHALL derive seg bit 7 as ~dp of the displayed digit, except when blink-blanked.
REQ-025 SHALL make lz_blank changes take effect at the next tick, with no frame-boundary gating.

Reset
REQ-026 SHALL, while rst=1 at an edge, set an to all ones, seg=8'hFF, frame_done=0, prescaler=0, idx=0, blink phase 0, blink frame count 0, and pending and active buffers to all zeros.
REQ-027 SHALL give rst priority over load and tick; the first tick after reset is a wrap: it displays digit NUM_DIGITS-1 and pulses frame_done.
REQ-028 SHALL, when rst asserts mid-frame, blank the display on the following edge.

Structure
REQ-029 SHALL place the 16 segment encodings and SEG_BLANK=8'hFF in shared package seg_pkg.
REQ-030 SHALL use one combinational sub-module seg_hex_decode (4-bit in, 7-bit active-low out).
REQ-031 SHALL contain no derived clocks; the prescaler produces a clock enable only.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-032 SHALL check reset then load 16'h1234: ticks every 4 cycles; an sequence 0111,1011,1101,1110 with seg 8'hF9,8'hA4,8'hB0,8'h99 from the second frame onward; frame_done every 16 cycles.
REQ-033 SHALL check load 16'h00A0 with lz_blank=1: digits 3,2 give seg 8'hFF, digit 1 gives 8'h88, digit 0 gives 8'hC0; with lz_blank=0, digits 3,2 give 8'hC0.
REQ-034 SHALL check a load mid-frame (idx=2) of 16'h5555 over 16'h1111: remaining slots of the frame show 1; the next frame shows all 5.
REQ-035 SHALL check blink_in=4'b0001, dp_in=4'b0001, value 16'h0008: digit 0 shows 8'h00 for 2 frames, then 8'hFF for 2 frames, repeating.
REQ-036 SHALL check load coincident with the wrap tick: the new value is displayed starting with that frame's first slot.
REQ-037 SHALL check rst asserted at idx=1: next edge gives an=4'hF and seg=8'hFF; after release, the first tick selects digit 3 and pulses frame_done.
